alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle unsigned shift-and-add multiplier sequencer built on the shared 16-bit alu.
//  Accepts a multiply command from the control unit and borrows the alu via AluOwn.
//  Drives AluOp/AluOp1/AluOp2 into the alu operand muxes and captures Result/Flags each step.
//  Returns the low WIDTH bits of the product and an overflow flag.
// PARAMETERS
//  WIDTH       16  operand/product width; must equal the alu datapath width
//  EARLY_EXIT  1   1: finish once the remaining multiplier is 0; 0: always run WIDTH bit-steps
// PORTS
//  Clock     in   1      system clock, all state on rising edge
//  Reset     in   1      synchronous, active-high reset
//  Start     in   1      command strobe, sampled only when Busy=0
//  OpA       in   WIDTH  multiplicand, latched on accepted Start
//  OpB       in   WIDTH  multiplier, latched on accepted Start
//  Busy      out  1      high from cycle after accepted Start until Done cycle inclusive
//  Done      out  1      one-cycle pulse: Product/Ovf valid
//  Product   out  WIDTH  low WIDTH bits of OpA*OpB, held until next accepted Start
//  Ovf       out  1      1 if true product exceeds WIDTH bits, held with Product
//  AluOwn    out  1      1 in ADD/SHIFT: datapath muxes select this block's alu inputs
//  AluOp     out  alu_functions_t  function to alu (FnA when not owning)
//  AluOp1    out  WIDTH  alu Op1
//  AluOp2    out  WIDTH  alu Op2
//  AluResult in   WIDTH  alu Result, same cycle (alu is combinational)
//  AluFlags  in   4      alu Flags; only the FLAGS_C bit is used
// BEHAVIOUR
//  Reset: state=IDLE; Busy=0, Done=0, Product=0, Ovf=0, AluOwn=0, AluOp=FnA, AluOp1=AluOp2=0.
//  Internal regs: Mcand, Mplier, Acc (WIDTH each), Cnt (bit-steps done), OvfR.
//  IDLE: Start=1 -> Mcand=OpA, Mplier=OpB, Acc=0, OvfR=0, Cnt=0 -> EVAL. Start while Busy is ignored.
//  EVAL (Busy, no alu use):
//   DONE if (EARLY_EXIT && Mplier==0) or Cnt==WIDTH;
//   else ADD if Mplier[0]=1;
//   else SHIFT.
//  ADD: AluOwn=1, AluOp=FnADD, Op1=Acc, Op2=Mcand.
//   Acc<=AluResult; OvfR|=AluFlags[FLAGS_C]. -> SHIFT.
//  SHIFT: AluOwn=1, AluOp=FnLSL, Op1=Mcand, Op2=1.
//   Mcand<=AluResult; Mplier<=Mplier>>1; Cnt++.
//   OvfR|=Mcand[WIDTH-1] & ((Mplier>>1)!=0). -> EVAL.
//  DONE: Done=1, Busy=1, Product<=Acc, Ovf<=OvfR. -> IDLE next cycle.
//   Product/Ovf update on the DONE edge and are visible from the cycle after Done.
//  AluOwn is registered-state decoded; it is never high in IDLE, EVAL or DONE.
//  Latency, Start accepted at cycle 0, EARLY_EXIT=1: Done at cycle 2*n+k+2.
//   n = index of the highest set bit of OpB, plus 1 (n=0 for OpB=0); k = popcount(OpB).
//  EARLY_EXIT=0: Done at cycle 2*WIDTH+k+2.
//  Start in the same cycle as Done is ignored (Busy=1); it is accepted next cycle in IDLE.
//  Reset mid-operation: abort to IDLE; Product/Ovf cleared; no Done pulse.
//  Arithmetic is unsigned modulo 2^WIDTH. Ovf is sticky across the whole operation.
// TESTING
//  Reset mid-run -> Busy/Done/AluOwn/Product/Ovf = 0 on the cycle after Reset.
//  Reset mid-run, then a fresh Start 3*5 -> Product=15.
//  OpA=3, OpB=5, EARLY_EXIT=1 -> Done at cycle 10, Product=15, Ovf=0.
//   AluOwn high at cycles 2,3,5,7,8 (ADD,SHIFT,SHIFT,ADD,SHIFT); AluOp at cycle 2 = FnADD.
//  OpA=0x1234, OpB=0 -> Done at cycle 2, Product=0, Ovf=0, AluOwn never asserted.
//  OpA=0x8000, OpB=2 -> Product=0, Ovf=1 (shift loss).
//  OpA=0xFFFF, OpB=0x0003 -> Product=0xFFFD, Ovf=1 (add carry).
//  OpA=0x00FF, OpB=0x0101 -> Product=0xFFFF, Ovf=0.
//  Back-to-back: Start held high continuously -> 2nd op accepted the cycle after Done.
//   Start while Busy -> no effect on latched operands.
//  EARLY_EXIT=0, OpB=1 -> Done at cycle 35.
//  Random 1000 pairs vs (OpA*OpB)[15:0] and (OpA*OpB)>16'hFFFF.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// Shared alu function encoding plus the command/alu bus of the
// shift-and-add multiplier sequencer.

package alu_mul_seq_pkg;
  typedef enum logic [3:0] {
    FnA   = 4'd0,
    FnB   = 4'd1,
    FnADD = 4'd2,
    FnSUB = 4'd3,
    FnAND = 4'd4,
    FnOR  = 4'd5,
    FnXOR = 4'd6,
    FnLSL = 4'd7,
    FnLSR = 4'd8
  } alu_functions_t;

  // Bit positions inside the 4-bit alu flags word
  localparam int FLAGS_Z = 0;
  localparam int FLAGS_C = 1;
  localparam int FLAGS_N = 2;
  localparam int FLAGS_V = 3;
endpackage

interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  import alu_mul_seq_pkg::*;

  // Command side (control unit)
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             ovf;

  // Borrowed alu side
  logic             alu_own;
  alu_functions_t   alu_op;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  // Environment: control unit plus the combinational alu
  modport master (
    output start, op_a, op_b, alu_result, alu_flags,
    input  busy, done, product, ovf, alu_own, alu_op, alu_op1, alu_op2
  );

  // The multiplier sequencer
  modport slave (
    input  start, op_a, op_b, alu_result, alu_flags,
    output busy, done, product, ovf, alu_own, alu_op, alu_op1, alu_op2
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared
// combinational alu for every add and every multiplicand shift.

module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  alu_mul_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_ADD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_acc_reg, ovf_acc_next;
  logic [WIDTH-1:0] product_reg, product_next;
  logic             ovf_reg, ovf_next;

  // Only the carry flag matters here; the rest of the flags word is sunk.
  logic unused_flags;
  assign unused_flags = ^{bus.alu_flags[3:2], bus.alu_flags[0]};

  // State and datapath registers, all cleared by reset (aborts a run, no Done)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_acc_reg <= 1'b0;
      product_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      ovf_acc_reg <= ovf_acc_next;
      product_reg <= product_next;
      ovf_reg     <= ovf_next;
    end
  end

  // Next-state and datapath updates; each bit-step is an optional ADD then a SHIFT
  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    ovf_acc_next = ovf_acc_reg;
    product_next = product_reg;
    ovf_next     = ovf_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_next   = bus.op_a;
          mplier_next  = bus.op_b;
          acc_next     = '0;
          cnt_next     = '0;
          ovf_acc_next = 1'b0;
          state_next   = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if ((EARLY_EXIT && (mplier_reg == '0)) || (cnt_reg == CNT_W'(WIDTH))) begin
          state_next = ST_DONE;
        end else if (mplier_reg[0]) begin
          state_next = ST_ADD;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_ADD: begin
        acc_next     = bus.alu_result;
        ovf_acc_next = ovf_acc_reg | bus.alu_flags[FLAGS_C];
        state_next   = ST_SHIFT;
      end
      ST_SHIFT: begin
        mcand_next  = bus.alu_result;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CNT_W'(1);
        // A multiplicand bit shifted out matters only if a higher multiplier bit
        // will still add it in.
        ovf_acc_next = ovf_acc_reg |
                       (mcand_reg[WIDTH-1] & ((mplier_reg >> 1) != '0));
        state_next  = ST_EVAL;
      end
      ST_DONE: begin
        product_next = acc_reg;
        ovf_next     = ovf_acc_reg;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Alu request decoded from the registered state only
  always_comb begin
    bus.alu_own = 1'b0;
    bus.alu_op  = FnA;
    bus.alu_op1 = '0;
    bus.alu_op2 = '0;
    if (state_reg == ST_ADD) begin
      bus.alu_own = 1'b1;
      bus.alu_op  = FnADD;
      bus.alu_op1 = acc_reg;
      bus.alu_op2 = mcand_reg;
    end else if (state_reg == ST_SHIFT) begin
      bus.alu_own = 1'b1;
      bus.alu_op  = FnLSL;
      bus.alu_op1 = mcand_reg;
      bus.alu_op2 = WIDTH'(1);
    end
  end

  assign bus.busy    = (state_reg != ST_IDLE);
  assign bus.done    = (state_reg == ST_DONE);
  assign bus.product = product_reg;
  assign bus.ovf     = ovf_reg;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: directed cases from the block description plus
// random operand pairs against a plain-arithmetic model.

module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic clk;
  logic rst;

  alu_mul_seq_if #(.WIDTH(16)) bus0 ();
  alu_mul_seq_if #(.WIDTH(16)) bus1 ();

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational alu seen by each sequencer: {flags, result}
  function automatic logic [19:0] alu_model(input alu_functions_t op,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [3:0]  f;
    s = {1'b0, a};
    case (op)
      FnA:   s = {1'b0, a};
      FnB:   s = {1'b0, b};
      FnADD: s = {1'b0, a} + {1'b0, b};
      FnLSL: s = {1'b0, a} << b[3:0];
      default: s = {1'b0, a};
    endcase
    f = '0;
    f[FLAGS_Z] = (s[15:0] == 16'h0);
    f[FLAGS_C] = s[16];
    f[FLAGS_N] = s[15];
    return {f, s[15:0]};
  endfunction

  logic [19:0] alu0_out, alu1_out;
  assign alu0_out = alu_model(bus0.alu_op, bus0.alu_op1, bus0.alu_op2);
  assign alu1_out = alu_model(bus1.alu_op, bus1.alu_op1, bus1.alu_op2);
  assign bus0.alu_result = alu0_out[15:0];
  assign bus0.alu_flags  = alu0_out[19:16];
  assign bus1.alu_result = alu1_out[15:0];
  assign bus1.alu_flags  = alu1_out[19:16];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [63:0]    trace_own;
  alu_functions_t op_at2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: index of highest set bit plus one
  function automatic int hi_bits(input logic [15:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic int exp_latency(input logic [15:0] b, input bit ee);
    return (ee ? 2 * hi_bits(b) : 32) + $countones(b) + 2;
  endfunction

  task automatic drive(input bit s, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (s) begin
      bus1.start = st; bus1.op_a = a; bus1.op_b = b;
    end else begin
      bus0.start = st; bus0.op_a = a; bus0.op_b = b;
    end
  endtask

  // Called in cycle 1 (one after accept); returns in the cycle after Done.
  task automatic wait_done(input bit s, output int cyc);
    int  c;
    bit  seen;
    trace_own = '0;
    op_at2    = FnA;
    seen      = 1'b0;
    c         = 1;
    cyc       = -1;
    while (!seen && c < 200) begin
      @(negedge clk);
      if ((s ? bus1.alu_own : bus0.alu_own) && c < 64) trace_own[c] = 1'b1;
      if (c == 2) op_at2 = s ? bus1.alu_op : bus0.alu_op;
      if (s ? bus1.done : bus0.done) begin
        seen = 1'b1;
        cyc  = c;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Called in cycle 0 with the DUT idle
  task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b, output int cyc);
    drive(s, 1'b1, a, b);
    @(posedge clk); #1;
    drive(s, 1'b0, 16'h0, 16'h0);
    wait_done(s, cyc);
    @(negedge clk);
    check("done_one_pulse", s ? bus1.done : bus0.done, 1'b0);
    check("idle_after_done", s ? bus1.busy : bus0.busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic op_and_check(input string tag, input bit s, input logic [15:0] a, input logic [15:0] b);
    int          cyc;
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    run_op(s, a, b, cyc);
    check({tag, "_product"}, s ? bus1.product : bus0.product, p[15:0]);
    check({tag, "_ovf"}, s ? bus1.ovf : bus0.ovf, p > 32'h0000_FFFF);
    check({tag, "_latency"}, cyc, exp_latency(b, s ? 1'b0 : 1'b1));
    check({tag, "_alu_steps"}, $countones(trace_own),
          (s ? 16 : hi_bits(b)) + $countones(b));
    $display("op dut%0d a=%04h b=%04h product=%04h ovf=%0b done_cycle=%0d", s, a, b,
             s ? bus1.product : bus0.product, s ? bus1.ovf : bus0.ovf, cyc);
  endtask

  initial begin
    int          cyc;
    int          done_seen;
    logic [15:0] ra, rb;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_done", bus0.done, 1'b0);
    check("rst_product", bus0.product, 16'h0);
    check("rst_ovf", bus0.ovf, 1'b0);
    check("rst_alu_own", bus0.alu_own, 1'b0);
    check("rst_alu_op", 64'(bus0.alu_op), 64'(FnA));
    check("rst_alu_op1", bus0.alu_op1, 16'h0);
    check("rst_alu_op2", bus0.alu_op2, 16'h0);
    check("rst_dut1_busy", bus1.busy, 1'b0);
    $display("reset state checked");
    @(posedge clk); #1;

    // 3 * 5: exact cycle trace
    run_op(1'b0, 16'd3, 16'd5, cyc);
    check("m3x5_done_cycle", cyc, 10);
    check("m3x5_product", bus0.product, 16'd15);
    check("m3x5_ovf", bus0.ovf, 1'b0);
    check("m3x5_own_trace", trace_own, 64'h1AC);
    check("m3x5_op_at2", 64'(op_at2), 64'(FnADD));
    $display("op 3*5 product=%0d done_cycle=%0d", bus0.product, cyc);

    // Reset in the middle of a run
    drive(1'b0, 1'b1, 16'h00FF, 16'hFFFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrun_busy", bus0.busy, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", bus0.busy, 1'b0);
    check("abort_done", bus0.done, 1'b0);
    check("abort_alu_own", bus0.alu_own, 1'b0);
    check("abort_product", bus0.product, 16'h0);
    check("abort_ovf", bus0.ovf, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus0.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    $display("mid-run reset checked");
    @(posedge clk); #1;
    op_and_check("after_abort_3x5", 1'b0, 16'd3, 16'd5);

    // Zero multiplier: immediate finish, alu never borrowed
    run_op(1'b0, 16'h1234, 16'h0000, cyc);
    check("zero_done_cycle", cyc, 2);
    check("zero_product", bus0.product, 16'h0);
    check("zero_ovf", bus0.ovf, 1'b0);
    check("zero_own_trace", trace_own, 64'h0);
    $display("op 1234*0 product=%04h done_cycle=%0d", bus0.product, cyc);

    // Boundary products
    op_and_check("shift_loss", 1'b0, 16'h8000, 16'h0002);
    check("shift_loss_ovf_set", bus0.ovf, 1'b1);
    op_and_check("add_carry", 1'b0, 16'hFFFF, 16'h0003);
    check("add_carry_product", bus0.product, 16'hFFFD);
    op_and_check("fill_ones", 1'b0, 16'h00FF, 16'h0101);
    check("fill_ones_product", bus0.product, 16'hFFFF);

    // Back-to-back with Start held high; operands change while busy
    drive(1'b0, 1'b1, 16'd7, 16'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'd9, 16'd11);
    wait_done(1'b0, cyc);
    check("b2b_first_cycle", cyc, 8);
    @(negedge clk);
    check("b2b_first_product", bus0.product, 16'd21);
    check("b2b_idle_gap", bus0.busy, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("b2b_second_accepted", bus0.busy, 1'b1);
    @(posedge clk); #1;
    wait_done(1'b0, cyc);
    check("b2b_second_cycle", cyc + 1, exp_latency(16'd11, 1'b1));
    check("b2b_second_product", bus0.product, 16'd99);
    $display("back-to-back first=21 second=%0d", bus0.product);

    // Fixed-length variant
    run_op(1'b1, 16'd3, 16'd1, cyc);
    check("noee_done_cycle", cyc, 35);
    check("noee_product", bus1.product, 16'd3);
    $display("op dut1 3*1 product=%0d done_cycle=%0d", bus1.product, cyc);
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      op_and_check("rand_noee", 1'b1, ra, rb);
    end

    // Random pairs, a quarter with small multipliers
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      op_and_check("rand", 1'b0, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
